l1_ptr_upd: RTL and testbench

//  Per-stream L1 read-pointer state for the multi-stream buffer. Sits downstream of the nports
//  l1_rd_port instances: consumes their transposed per-stream request handshakes, counts the

---
 rtl/l1_ptr_upd_if.sv | 23 ++
 rtl/l1_ptr_upd.sv | 116 +++++++++++
 tb/tb_l1_ptr_upd.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/l1_ptr_upd_if.sv
// Request/init handshake bundle between the l1_rd_port array and l1_ptr_upd.
// master = request side (l1_rd_port array), slave = l1_ptr_upd.
interface l1_ptr_upd_if #(
  parameter int nstrms    = 64,
  parameter int sid_width = $clog2(nstrms),
  parameter int nports    = 8
);
  logic [nports*nstrms-1:0] i_req_v;
  logic [nports*nstrms-1:0] i_req_r;
  logic                     i_rst_v;
  logic                     i_rst_r;
  logic [sid_width-1:0]     i_rst_sid;

  modport master (
    output i_req_v, i_rst_v, i_rst_sid,
    input  i_req_r, i_rst_r
  );

  modport slave (
    input  i_req_v, i_rst_v, i_rst_sid,
    output i_req_r, i_rst_r
  );
endinterface

// File: rtl/l1_ptr_upd.sv
// Per-stream L1 read-pointer state. Counts accepted requests per stream each
// cycle and advances that stream's pointer by the count (wrapping). Handles
// stream init commands, which rewind the pointer and mark the stream active.
// Optional: define L1_PTR_ERR_EN to build the sticky protocol-error check.
module l1_ptr_upd #(
  parameter int nstrms    = 64,
  parameter int sid_width = $clog2(nstrms),
  parameter int nports    = 8,
  parameter int ptr_width = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  l1_ptr_upd_if.slave                 bus,
  output logic [nstrms*ptr_width-1:0] o_ptrs,
  output logic [nstrms-1:0]           o_act,
  output logic                        o_err
);

  localparam int CW = $clog2(nports + 1);

  logic [ptr_width-1:0] r_ptr [nstrms];
  logic [nstrms-1:0]    r_act;
  logic [nstrms-1:0]    w_init;
  logic [nstrms-1:0]    w_rdy;
  logic [CW-1:0]        w_cnt [nstrms];

  assign bus.i_rst_r = 1'b1;
  assign o_act       = r_act;

  // Decode the init target and form per-stream ready (init on a stream blocks its requests).
  always_comb begin
    w_init = '0;
    w_rdy  = '0;
    for (int unsigned s = 0; s < nstrms; s++) begin
      w_init[s] = bus.i_rst_v & (bus.i_rst_sid == sid_width'(s));
      w_rdy[s]  = r_act[s] & ~w_init[s];
    end
  end

  // Ready is replicated across all ports of a stream; independent of any valid.
  always_comb begin
    bus.i_req_r = '0;
    for (int unsigned p = 0; p < nports; p++)
      for (int unsigned s = 0; s < nstrms; s++)
        bus.i_req_r[p*nstrms + s] = w_rdy[s];
  end

  // Popcount of accepted requests per stream over all ports.
  always_comb begin
    for (int unsigned s = 0; s < nstrms; s++) begin
      w_cnt[s] = '0;
      for (int unsigned p = 0; p < nports; p++)
        w_cnt[s] = w_cnt[s] + CW'(bus.i_req_v[p*nstrms + s] & w_rdy[s]);
    end
  end

  // Pointer/active registers: init rewinds, otherwise advance by the accept count (mod 2**ptr_width).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act <= '0;
      for (int unsigned s = 0; s < nstrms; s++)
        r_ptr[s] <= '0;
    end else begin
      for (int unsigned s = 0; s < nstrms; s++) begin
        if (w_init[s]) begin
          r_ptr[s] <= '0;
          r_act[s] <= 1'b1;
        end else begin
          r_ptr[s] <= r_ptr[s] + ptr_width'(w_cnt[s]);
        end
      end
    end
  end

  // Flatten pointer array onto the output bus.
  always_comb begin
    o_ptrs = '0;
    for (int unsigned s = 0; s < nstrms; s++)
      o_ptrs[s*ptr_width +: ptr_width] = r_ptr[s];
  end

`ifdef L1_PTR_ERR_EN
  logic w_err_det;
  logic w_seen;
  logic r_err;

  // Flag requests to inactive streams and ports asserting more than one stream.
  always_comb begin
    w_err_det = 1'b0;
    w_seen    = 1'b0;
    for (int unsigned p = 0; p < nports; p++) begin
      w_seen = 1'b0;
      for (int unsigned s = 0; s < nstrms; s++) begin
        if (bus.i_req_v[p*nstrms + s]) begin
          if (!r_act[s] || w_seen)
            w_err_det = 1'b1;
          w_seen = 1'b1;
        end
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_err <= 1'b0;
    else if (w_err_det)
      r_err <= 1'b1;
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_l1_ptr_upd.sv
// Directed self-checking bench for l1_ptr_upd (nstrms=4, nports=2, ptr_width=4).
module tb_l1_ptr_upd;
  localparam int NS = 4;
  localparam int NP = 2;
  localparam int PW = 4;
  localparam int SW = 2;
`ifdef L1_PTR_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk;
  logic reset;
  logic [NS*PW-1:0] o_ptrs;
  logic [NS-1:0]    o_act;
  logic             o_err;
  int errors = 0;
  int checks = 0;

  l1_ptr_upd_if #(.nstrms(NS), .sid_width(SW), .nports(NP)) bus ();

  l1_ptr_upd #(.nstrms(NS), .sid_width(SW), .nports(NP), .ptr_width(PW)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus.slave),
    .o_ptrs (o_ptrs),
    .o_act  (o_act),
    .o_err  (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.i_req_v   = '0;
    bus.i_rst_v   = 1'b0;
    bus.i_rst_sid = '0;
    #12;
    chk("rst_ptrs", 32'(o_ptrs), 32'h0);
    chk("rst_act", 32'(o_act), 32'h0);
    chk("rst_err", 32'(o_err), 32'h0);
    chk("rst_rdy", 32'(bus.i_req_r), 32'h0);
    chk("rst_rstr", 32'(bus.i_rst_r), 32'h1);
    reset = 1'b0;
    tick();

    // 1: request to uninitialised stream 1 from port0
    bus.i_req_v = 8'h02;
    #1;
    chk("t1_rdy", 32'(bus.i_req_r), 32'h0);
    tick();
    bus.i_req_v = '0;
    chk("t1_ptrs", 32'(o_ptrs), 32'h0);
    chk("t1_err", 32'(o_err), 32'(EXP_ERR));

    // 2: init sid 2, then both ports request stream 2
    bus.i_rst_v = 1'b1; bus.i_rst_sid = 2'd2;
    tick();
    bus.i_rst_v = 1'b0;
    chk("t2_act", 32'(o_act), 32'h4);
    bus.i_req_v = 8'h44;
    #1;
    chk("t2_rdy", 32'(bus.i_req_r), 32'h44);
    tick();
    bus.i_req_v = '0;
    chk("t2_ptrs", 32'(o_ptrs), 32'h0200);

    // 3: init sid 3, drive ptr[3] to 15, then 2 requests wrap to 1
    bus.i_rst_v = 1'b1; bus.i_rst_sid = 2'd3;
    tick();
    bus.i_rst_v = 1'b0;
    chk("t3_act", 32'(o_act), 32'hC);
    bus.i_req_v = 8'h88;
    for (int i = 0; i < 7; i++) tick();
    bus.i_req_v = 8'h08;
    tick();
    chk("t3_ptr15", 32'(o_ptrs), 32'hF200);
    bus.i_req_v = 8'h88;
    tick();
    bus.i_req_v = '0;
    chk("t3_wrap", 32'(o_ptrs), 32'h1200);
    chk("t3_act2", 32'(o_act), 32'hC);

    // 4: ptr[0]=5, then init sid 0 together with a port1 request to stream 0
    bus.i_rst_v = 1'b1; bus.i_rst_sid = 2'd0;
    tick();
    bus.i_rst_v = 1'b0;
    bus.i_req_v = 8'h11;
    tick(); tick();
    bus.i_req_v = 8'h01;
    tick();
    bus.i_req_v = '0;
    chk("t4_ptr5", 32'(o_ptrs), 32'h1205);
    bus.i_rst_v = 1'b1; bus.i_rst_sid = 2'd0;
    bus.i_req_v = 8'h10;
    #1;
    chk("t4_rdy", 32'(bus.i_req_r), 32'hCC);
    tick();
    bus.i_rst_v = 1'b0;
    bus.i_req_v = '0;
    chk("t4_rewind", 32'(o_ptrs), 32'h1200);
    chk("t4_act", 32'(o_act), 32'hD);

    // 5: init s1 while s0 accepts, then s0/s1 in parallel for 3 cycles
    bus.i_rst_v = 1'b1; bus.i_rst_sid = 2'd1;
    bus.i_req_v = 8'h01;
    tick();
    bus.i_rst_v = 1'b0;
    chk("t5_mixed", 32'(o_ptrs), 32'h1201);
    chk("t5_act", 32'(o_act), 32'hF);
    bus.i_req_v = 8'h21;
    tick(); tick(); tick();
    chk("t5_ptrs", 32'(o_ptrs), 32'h1234);
    chk("t5_err", 32'(o_err), 32'(EXP_ERR));

    // 6: async reset between edges with requests pending
    #2;
    reset = 1'b1;
    #1;
    chk("t6_ptrs", 32'(o_ptrs), 32'h0);
    chk("t6_act", 32'(o_act), 32'h0);
    chk("t6_err", 32'(o_err), 32'h0);
    chk("t6_rdy", 32'(bus.i_req_r), 32'h0);
    bus.i_req_v = '0;
    tick();
    reset = 1'b0;
    tick();
    chk("t6_hold", 32'(o_ptrs), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end
endmodule
